// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-flip-flop based modulo-N counter.
//   JK_HOLD / JK_CLR / JK_SET / JK_TOG : {J,K} excitation codes
//   jk_pair_t                          : 2-bit {J,K} pair applied to one cell
// ---------------------------------------------------------------------------
package jk_pkg;

   typedef logic [1:0] jk_pair_t;

   localparam jk_pair_t JK_HOLD = 2'b00;
   localparam jk_pair_t JK_CLR  = 2'b01;
   localparam jk_pair_t JK_SET  = 2'b10;
   localparam jk_pair_t JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// ---------------------------------------------------------------------------
// jk_ff_cell
// Single-bit JK storage element, rising-edge clocked.
// Ports:
//   J, K  : excitation inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   clk   : clock
//   reset : synchronous active-high reset, dominates J/K
//   Q     : stored bit
// ---------------------------------------------------------------------------
module jk_ff_cell
   import jk_pkg::*;
(
   input  logic J,
   input  logic K,
   input  logic clk,
   input  logic reset,
   output logic Q
);

   logic     q_reg;
   jk_pair_t pair;

   assign pair = {J, K};

   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg <= 1'b0;
      end else begin
         case (pair)
            JK_HOLD: q_reg <= q_reg;
            JK_CLR:  q_reg <= 1'b0;
            JK_SET:  q_reg <= 1'b1;
            JK_TOG:  q_reg <= ~q_reg;
            default: q_reg <= q_reg;
         endcase
      end
   end

   assign Q = q_reg;

endmodule

// File: rtl/jk_mod_counter.sv
// ---------------------------------------------------------------------------
// jk_mod_counter
// Synchronous modulo-MODULUS up/down counter stored in a bank of JK cells.
// This level only computes the next count and the J/K excitation; the
// state itself lives in the jk_ff_cell instances.
// Optional feature macro: JK_COUNTER_LOAD_EN (adds load / load_val).
// Ports:
//   clk      : clock
//   reset    : synchronous active-high, clears the count
//   en       : count enable
//   up       : 1 = increment, 0 = decrement
//   load     : (JK_COUNTER_LOAD_EN) parallel load, beats en
//   load_val : (JK_COUNTER_LOAD_EN) value to load, saturated to MODULUS-1
//   q        : present count (cell Q outputs)
//   tc       : terminal count, combinational, high in the wrapping cycle
//   j_vec    : J inputs applied to the cells
//   k_vec    : K inputs applied to the cells
// ---------------------------------------------------------------------------
module jk_mod_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
`ifdef JK_COUNTER_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec
);

   localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH-1:0] count_next;
   logic             at_max;
   logic             at_min;
   logic             tc_count;

   assign q_ext  = {1'b0, q};
   assign at_max = (q == MAX_COUNT);
   assign at_min = (q == '0);

   // Count path. Values >= MODULUS (only reachable by loading) wrap:
   // upward to 0, downward to q-1 if that is legal, else to MODULUS-1.
   always_comb begin
      count_next = q;
      if (en) begin
         if (up) begin
            if (q_ext >= MOD_EXT - 1'b1) begin
               count_next = '0;
            end else begin
               count_next = q + 1'b1;
            end
         end else begin
            if (at_min) begin
               count_next = MAX_COUNT;
            end else if ((q_ext - 1'b1) < MOD_EXT) begin
               count_next = q - 1'b1;
            end else begin
               count_next = MAX_COUNT;
            end
         end
      end
   end

   assign tc_count = en & ((up & at_max) | (~up & at_min));

`ifdef JK_COUNTER_LOAD_EN
   logic [WIDTH-1:0] load_sat;

   assign load_sat = ({1'b0, load_val} >= MOD_EXT) ? MAX_COUNT : load_val;
   assign tc       = tc_count & ~load;
`else
   assign tc       = tc_count;
`endif

   // Per-bit excitation and storage. The count path only ever produces
   // hold/set/clear; reset forces clear on every cell (the cell reset also
   // dominates), and load drives J=val, K=~val.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_pair_t pair;

      always_comb begin
         pair = {count_next[gi] & ~q[gi], ~count_next[gi] & q[gi]};
`ifdef JK_COUNTER_LOAD_EN
         if (load) begin
            pair = {load_sat[gi], ~load_sat[gi]};
         end
`endif
         if (reset) begin
            pair = JK_CLR;
         end
      end

      assign j_vec[gi] = pair[1];
      assign k_vec[gi] = pair[0];

      jk_ff_cell u_cell (
         .J     (pair[1]),
         .K     (pair[0]),
         .clk   (clk),
         .reset (reset),
         .Q     (q[gi])
      );
   end

endmodule
